// File: rtl/psum_acc_if.sv
// Job control, Psum input and beat output bundle between the adder tree, psum_acc and the output buffer.
// The master drives start/nround/Psum/out_ready; the slave (psum_acc) drives the beat stream and status.
interface psum_acc_if #(
   parameter int LANES = 36,
   parameter int W     = 24,
   parameter int BEATS = 3
);
   logic                        start;
   logic [2:0]                  nround;
   logic                        Psum_valid;
   logic [LANES*W-1:0]          Psum;
   logic                        out_ready;
   logic                        out_valid;
   logic [(LANES/BEATS)*W-1:0]  out_data;
   logic                        out_last;
   logic                        busy;
   logic                        ovf;
   logic                        drop;

   modport master (
      output start, nround, Psum_valid, Psum, out_ready,
      input  out_valid, out_data, out_last, busy, ovf, drop
   );

   modport slave (
      input  start, nround, Psum_valid, Psum, out_ready,
      output out_valid, out_data, out_last, busy, ovf, drop
   );
endinterface

// File: rtl/psum_acc.sv
// Lane-wise saturating accumulation of Psum words over 1..8 rounds, then a 3-beat drain; beat 0 is valid
// the cycle after the final-round Psum_valid, and out_ready low simply holds the current beat.
module psum_acc #(
   parameter int LANES = 36,
   parameter int W     = 24,
   parameter int BEATS = 3
) (
   input  logic      clk,
   input  logic      rst,
   psum_acc_if.slave bus
);
   localparam int LPB = LANES / BEATS;
   localparam int BW  = LPB * W;
   localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

   state_t         state;
   logic [2:0]     rnd;
   logic [2:0]     nround_q;
   logic [BCW-1:0] beat;
   logic [BCW-1:0] nxt_beat;
   logic [W-1:0]   acc     [LANES];
   logic [W-1:0]   acc_upd [LANES];
   logic           upd_ovf;
   logic [BW-1:0]  first_dat;
   logic [BW-1:0]  next_dat;

   // Round 0 loads the raw lane; later rounds add with clamping to the signed W-bit range.
   always_comb begin
      logic [W:0]   sum;
      logic [W-1:0] lane;
      upd_ovf = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         lane = bus.Psum[i*W +: W];
         sum  = {acc[i][W-1], acc[i]} + {lane[W-1], lane};
         if (rnd == 3'd0) begin
            acc_upd[i] = lane;
         end else if (sum[W] != sum[W-1]) begin
            acc_upd[i] = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            upd_ovf    = 1'b1;
         end else begin
            acc_upd[i] = sum[W-1:0];
         end
      end
   end

   always_comb begin
      nxt_beat = (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      for (int j = 0; j < LPB; j++) begin
         first_dat[j*W +: W] = acc_upd[j];
         next_dat[j*W +: W]  = acc[int'(nxt_beat)*LPB + j];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         rnd           <= '0;
         nround_q      <= '0;
         beat          <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.ovf       <= 1'b0;
         bus.drop      <= 1'b0;
         for (int i = 0; i < LANES; i++) acc[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= ACC;
                  nround_q <= bus.nround;
                  rnd      <= '0;
                  bus.ovf  <= 1'b0;
                  bus.drop <= 1'b0;
                  bus.busy <= 1'b1;
               end else if (bus.Psum_valid) begin
                  bus.drop <= 1'b1;
               end
            end
            ACC: begin
               if (bus.Psum_valid) begin
                  for (int i = 0; i < LANES; i++) acc[i] <= acc_upd[i];
                  bus.ovf <= bus.ovf | upd_ovf;
                  rnd     <= rnd + 3'd1;
                  if (rnd == nround_q) begin
                     // Beat 0 comes straight from the update so it is valid on the very next cycle.
                     state         <= DRAIN;
                     beat          <= '0;
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= first_dat;
                     bus.out_last  <= (LAST_BEAT == '0);
                  end
               end
            end
            DRAIN: begin
               if (bus.Psum_valid) bus.drop <= 1'b1;
               if (bus.out_ready) begin
                  if (beat == LAST_BEAT) begin
                     state         <= IDLE;
                     beat          <= '0;
                     bus.out_valid <= 1'b0;
                     bus.out_data  <= '0;
                     bus.out_last  <= 1'b0;
                     bus.busy      <= 1'b0;
                  end else begin
                     beat         <= nxt_beat;
                     bus.out_data <= next_dat;
                     bus.out_last <= (nxt_beat == LAST_BEAT);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_psum_acc.sv
// Directed bench for psum_acc: pass-through, multi-round sums, saturation, stalls, protocol errors, reset.
module tb_psum_acc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [23:0] in_lane  [36];
   logic [23:0] exp_lane [36];

   psum_acc_if bus ();
   psum_acc dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [863:0] pack_in();
      logic [863:0] r;
      for (int i = 0; i < 36; i++) r[i*24 +: 24] = in_lane[i];
      return r;
   endfunction

   function automatic logic [287:0] exp_beat(input int b);
      logic [287:0] r;
      for (int j = 0; j < 12; j++) r[j*24 +: 24] = exp_lane[b*12 + j];
      return r;
   endfunction

   task automatic fill_in(input logic [23:0] v);
      for (int i = 0; i < 36; i++) in_lane[i] = v;
   endtask

   task automatic fill_exp(input logic [23:0] v);
      for (int i = 0; i < 36; i++) exp_lane[i] = v;
   endtask

   task automatic send_word();
      bus.Psum       = pack_in();
      bus.Psum_valid = 1'b1;
      tick();
      bus.Psum_valid = 1'b0;
      bus.Psum       = '0;
   endtask

   task automatic start_job(input logic [2:0] n);
      bus.start  = 1'b1;
      bus.nround = n;
      tick();
      bus.start  = 1'b0;
   endtask

   // Expects beat 0 already on the bus and out_ready high; walks all three beats.
   task automatic drain_check(input string tag);
      for (int b = 0; b < 3; b++) begin
         chk({tag, "_valid"}, bus.out_valid, 1'b1);
         chk({tag, "_data"}, bus.out_data, exp_beat(b));
         chk({tag, "_last"}, bus.out_last, (b == 2));
         tick();
      end
      chk({tag, "_done_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_done_busy"}, bus.busy, 1'b0);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.nround     = '0;
      bus.Psum_valid = 1'b0;
      bus.Psum       = '0;
      bus.out_ready  = 1'b0;
      fill_in('0);
      fill_exp('0);

      // Reset state
      tick();
      tick();
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_data", bus.out_data, '0);
      chk("rst_last", bus.out_last, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ovf", bus.ovf, 1'b0);
      chk("rst_drop", bus.drop, 1'b0);
      rst = 1'b0;
      tick();

      // Single-round pass-through, lane i = i
      start_job(3'd0);
      chk("t1_busy_rise", bus.busy, 1'b1);
      for (int i = 0; i < 36; i++) begin
         in_lane[i]  = 24'(i);
         exp_lane[i] = 24'(i);
      end
      bus.out_ready = 1'b1;
      send_word();
      drain_check("t1");
      chk("t1_ovf", bus.ovf, 1'b0);

      // Four rounds of 0x10 with gaps 0,1,2 -> 0x40
      start_job(3'd3);
      fill_in(24'h000010);
      fill_exp(24'h000040);
      send_word();
      send_word();
      tick();
      send_word();
      tick();
      tick();
      chk("t2_wait_valid", bus.out_valid, 1'b0);
      chk("t2_wait_busy", bus.busy, 1'b1);
      send_word();
      drain_check("t2");

      // Saturation over two rounds, then drained under backpressure
      bus.out_ready = 1'b0;
      start_job(3'd1);
      fill_in('0);
      in_lane[0] = 24'h7FFFF0;
      in_lane[1] = 24'h800010;
      in_lane[2] = 24'h000005;
      send_word();
      chk("t3_ovf_round0", bus.ovf, 1'b0);
      in_lane[0] = 24'h000100;
      in_lane[1] = 24'hFFFF00;
      in_lane[2] = 24'hFFFFFB;
      send_word();
      fill_exp('0);
      exp_lane[0] = 24'h7FFFFF;
      exp_lane[1] = 24'h800000;
      exp_lane[2] = 24'h000000;
      chk("t3_ovf", bus.ovf, 1'b1);
      for (int b = 0; b < 3; b++) begin
         for (int s = 0; s < 3; s++) begin
            chk("t4_stall_valid", bus.out_valid, 1'b1);
            chk("t4_stall_data", bus.out_data, exp_beat(b));
            chk("t4_stall_last", bus.out_last, (b == 2));
            tick();
         end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end
      chk("t4_done_valid", bus.out_valid, 1'b0);
      chk("t4_done_busy", bus.busy, 1'b0);
      chk("t4_ovf_sticky", bus.ovf, 1'b1);

      // Protocol errors
      bus.Psum_valid = 1'b1;
      tick();
      bus.Psum_valid = 1'b0;
      chk("t5_drop_idle", bus.drop, 1'b1);
      start_job(3'd1);
      chk("t5_drop_clear", bus.drop, 1'b0);
      chk("t5_ovf_clear", bus.ovf, 1'b0);
      fill_in(24'h000001);
      send_word();
      start_job(3'd0);
      chk("t5_restart_busy", bus.busy, 1'b1);
      chk("t5_restart_valid", bus.out_valid, 1'b0);
      fill_in(24'h000002);
      send_word();
      fill_exp(24'h000003);
      chk("t5_sum_valid", bus.out_valid, 1'b1);
      chk("t5_sum_beat0", bus.out_data, exp_beat(0));
      fill_in(24'h000055);
      send_word();
      chk("t5_drop_drain", bus.drop, 1'b1);
      chk("t5_hold_beat0", bus.out_data, exp_beat(0));
      bus.out_ready = 1'b1;
      tick();
      chk("t5_beat1", bus.out_data, exp_beat(1));
      tick();
      chk("t5_beat2", bus.out_data, exp_beat(2));
      chk("t5_last", bus.out_last, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("t5_late_start_busy", bus.busy, 1'b0);
      tick();
      chk("t5_late_start_idle", bus.busy, 1'b0);

      // Reset in ACC after 2 of 4 rounds
      start_job(3'd3);
      fill_in(24'h000100);
      send_word();
      send_word();
      #2 rst = 1'b1;
      #1;
      chk("t6_acc_rst_busy", bus.busy, 1'b0);
      chk("t6_acc_rst_valid", bus.out_valid, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      // Reset during stalled beat 1
      start_job(3'd1);
      fill_in(24'h000007);
      send_word();
      send_word();
      fill_exp(24'h00000E);
      tick();
      bus.out_ready = 1'b0;
      chk("t6_stall_beat1", bus.out_data, exp_beat(1));
      #2 rst = 1'b1;
      #1;
      chk("t6_drn_rst_valid", bus.out_valid, 1'b0);
      chk("t6_drn_rst_data", bus.out_data, '0);
      chk("t6_drn_rst_last", bus.out_last, 1'b0);
      chk("t6_drn_rst_busy", bus.busy, 1'b0);
      tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      chk("t6_no_partial", bus.out_valid, 1'b0);

      // Fresh job after reset: 4 + 5 = 9 in every lane
      start_job(3'd1);
      fill_in(24'h000004);
      send_word();
      fill_in(24'h000005);
      send_word();
      fill_exp(24'h000009);
      drain_check("t6_new");
      chk("t6_new_ovf", bus.ovf, 1'b0);
      chk("t6_new_drop", bus.drop, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/psum_acc.md
# psum_acc

Partial-sum accumulator at the output end of the adder tree. It captures each 864-bit `Psum` word on `Psum_valid` and accumulates the words lane-wise over a programmable number of weight rounds, using signed saturating arithmetic. It then drains the result to the output buffer as three beats under a valid/ready handshake. It is the consumer side of the adder's `Psum_valid`/`Psum` interface.

## Interface
- `LANES`, 36, number of signed partial-sum lanes in `Psum`
- `W`, 24, lane width in bits; `Psum` width = LANES*W = 864
- `BEATS`, 3, output beats per result; beat width = LANES/BEATS*W = 288
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous reset, active-high; clears all state immediately
- `start`  in  1  one-cycle pulse that begins a job; sampled only in IDLE
- `nround`  in  3  rounds-1 for the job (0..7 → 1..8 rounds); latched on accepted `start`
- `Psum_valid`  in  1  a `Psum` word is present this cycle
- `Psum`  in  864  lane i = `Psum[i*W +: W]`, two's complement
- `out_ready`  in  1  output buffer can accept a beat
- `out_valid`  out  1  beat available on `out_data`
- `out_data`  out  288  beat b carries lanes b*12..b*12+11, lane j of the beat at `[j*W +: W]`
- `out_last`  out  1  high with beat BEATS-1
- `busy`  out  1  high in ACC and DRAIN
- `ovf`  out  1  sticky: at least one lane saturated during the current job
- `drop`  out  1  sticky: a `Psum_valid` arrived outside ACC

## Operation
- States: IDLE, ACC, DRAIN.
- IDLE:
  - `start` → ACC; latch `nround`; clear round counter, `ovf` and `drop`.
  - `Psum_valid` in IDLE sets `drop`; the data is discarded.
- ACC, on each `Psum_valid`:
  - Round 0: load acc[i] = Psum lane i (plain load, no add).
  - Later rounds: acc[i] = sat(acc[i] + lane i).
  - Round counter increments.
  - When the accepted word is round `nround`, go to DRAIN with beat counter = 0.
  - Cycles without `Psum_valid` hold all state.
- Saturating add:
  - Sign-extend both operands to W+1 bits and add.
  - A result above 0x7FFFFF clamps to 0x7FFFFF; a result below 0x800000 (as signed) clamps to 0x800000.
  - Any clamp sets `ovf`.
- DRAIN:
  - `out_valid` = 1; `out_data` = acc lanes of the current beat.
  - On `out_valid && out_ready` the beat counter advances.
  - The transfer of beat BEATS-1 returns the block to IDLE.
  - `Psum_valid` in DRAIN sets `drop`; acc is untouched.
- `start` outside IDLE is ignored.
- `ovf` and `drop` keep their values through IDLE until the next accepted `start`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `ovf`=0, `drop`=0. State = IDLE, acc = 0, counters = 0.
- `busy` rises the cycle after `start` is accepted.
- Latency: the final-round `Psum_valid` is sampled at edge k. `out_valid` is high from k+1 with beat 0.
- With `out_ready` held high, beats 0, 1, 2 appear on cycles k+1, k+2, k+3. `busy` falls at k+4.
- While `out_valid && !out_ready`, `out_data` and `out_last` hold stable.
- A `start` in the same cycle as the final beat's transfer is ignored, because the block is not yet in IDLE.
- `rst` asserted mid-job aborts immediately: outputs go to their reset values and acc is cleared. No partial beat is emitted after `rst` deasserts.
- Single-round job (`nround`=0): one `Psum_valid` goes straight to DRAIN with acc equal to the raw `Psum`.

## Test plan
- Single-round pass-through: `start` with `nround`=0, one `Psum` with lane i = i, `out_ready`=1 → three beats on consecutive cycles. Beat 0 lanes = 0..11, beat 2 lanes = 24..35. `out_last` on beat 2 only; `ovf`=0.
- Multi-round accumulate: `nround`=3, four words with every lane = 0x000010, valid gaps of 0–2 cycles → every output lane = 0x000040; `out_valid` the cycle after the 4th valid.
- Saturation: `nround`=1.
  - Lane 0: 0x7FFFF0 + 0x000100 → 0x7FFFFF.
  - Lane 1: 0x800010 + 0xFFFF00 → 0x800000.
  - Lane 2: 0x000005 + 0xFFFFFB → 0x000000.
  - `ovf`=1.
- Backpressure: during drain, `out_ready` low for 3 cycles on each beat → `out_data`/`out_last` stable while stalled; exactly 3 transfers; `busy` falls after the third.
- Protocol errors: `Psum_valid` in IDLE, then `start`, and `start` pulsed again mid-ACC.
  - `drop`=1 before `start`, cleared by the accepted `start`.
  - The second `start` is ignored and the round count is unaffected.
  - `Psum_valid` during DRAIN sets `drop` and leaves the output data unchanged.
- Reset mid-operation: assert `rst` during ACC after 2 of 4 rounds, and again during a stalled beat 1 → all outputs 0 asynchronously. A new job after reset produces correct sums with no residue from the aborted job.
